// File: rtl/minn_window_sum_mc_if.sv
// Purpose: config, sample and result bundle for the multi-channel window sum.
// Latency: none, wires only; timing is owned by minn_window_sum_mc.
// Backpressure: none; the sample side has a strobe but no ready.
interface minn_window_sum_mc_if #(
  parameter int WIDTH     = 16,
  parameter int MAX_DEPTH = 64,
  parameter int CHANNELS  = 2
);
  localparam int DW = $clog2(MAX_DEPTH + 1);
  localparam int SW = WIDTH + DW;

  logic [DW-1:0]             cfg_depth;
  logic                      cfg_load;
  logic                      in_valid;
  logic [CHANNELS*WIDTH-1:0] sample_in;
  logic [CHANNELS*SW-1:0]    sum_out;
  logic                      out_valid;
  logic                      sum_valid;
  logic [DW-1:0]             fill_level;
  logic [DW-1:0]             depth_active;

  modport master (
    output cfg_depth, cfg_load, in_valid, sample_in,
    input  sum_out, out_valid, sum_valid, fill_level, depth_active
  );

  modport slave (
    input  cfg_depth, cfg_load, in_valid, sample_in,
    output sum_out, out_valid, sum_valid, fill_level, depth_active
  );
endinterface

// File: rtl/minn_window_sum_mc.sv
// Purpose: per-lane sliding-window sum over the last N samples, N programmable at runtime.
// Latency: 1 cycle from an accepted sample to sum_out/out_valid.
// Backpressure: none; a sample is taken every cycle in_valid is high.
module minn_window_sum_mc #(
  parameter int WIDTH     = 16,
  parameter int MAX_DEPTH = 64,
  parameter int CHANNELS  = 2
) (
  input  logic                clk,
  input  logic                rst,
  minn_window_sum_mc_if.slave bus
);
  localparam int DW = $clog2(MAX_DEPTH + 1);
  localparam int SW = WIDTH + DW;
  localparam int PW = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;

  // FILL: window not yet holding N samples, nothing to subtract.
  // RUN: window full, every new sample retires the oldest one.
  typedef enum logic {FILL, RUN} state_t;

  state_t                    state, state_nxt;
  logic [DW-1:0]             depth_q, depth_nxt;
  logic [DW-1:0]             fill_q, fill_nxt;
  logic [DW-1:0]             cfg_n;
  logic [PW-1:0]             wr_ptr, wr_ptr_nxt, wr_addr;
  logic [CHANNELS*SW-1:0]    sum_q, sum_nxt;
  logic                      out_valid_q;
  logic [CHANNELS*WIDTH-1:0] oldest;

  // Sample history; never cleared, stale words are masked by the FILL state.
  logic [WIDTH-1:0] mem [CHANNELS][MAX_DEPTH];

  function automatic logic [SW-1:0] sext(input logic [WIDTH-1:0] v);
    return {{DW{v[WIDTH-1]}}, v};
  endfunction

  // Clamp the requested window length into 1..MAX_DEPTH.
  always_comb begin
    cfg_n = bus.cfg_depth;
    if (bus.cfg_depth == '0) begin
      cfg_n = DW'(1);
    end else if (bus.cfg_depth > DW'(MAX_DEPTH)) begin
      cfg_n = DW'(MAX_DEPTH);
    end
  end

  // Oldest sample sits at the write pointer and is read before this cycle's overwrite.
  always_comb begin
    oldest = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      oldest[k*WIDTH +: WIDTH] = mem[k][wr_ptr];
    end
  end

  // Next-state for FSM, window length, fill count and write pointer.
  always_comb begin
    state_nxt  = state;
    depth_nxt  = depth_q;
    fill_nxt   = fill_q;
    wr_ptr_nxt = wr_ptr;
    wr_addr    = wr_ptr;
    if (bus.cfg_load) begin
      // Restart; a coincident sample becomes the first of the new window.
      depth_nxt = cfg_n;
      wr_addr   = '0;
      if (bus.in_valid) begin
        fill_nxt   = DW'(1);
        wr_ptr_nxt = (cfg_n == DW'(1)) ? '0 : PW'(1);
        state_nxt  = (cfg_n == DW'(1)) ? RUN : FILL;
      end else begin
        fill_nxt   = '0;
        wr_ptr_nxt = '0;
        state_nxt  = FILL;
      end
    end else if (bus.in_valid) begin
      // Pointer wraps at N-1, not at the end of storage.
      wr_ptr_nxt = (DW'(wr_ptr) == depth_q - DW'(1)) ? '0 : wr_ptr + PW'(1);
      if (state == FILL) begin
        fill_nxt = fill_q + DW'(1);
        if (fill_q + DW'(1) == depth_q) begin
          state_nxt = RUN;
        end
      end
    end
  end

  // Per-lane running sum: add the new sample, retire the oldest once the window is full.
  always_comb begin
    sum_nxt = sum_q;
    for (int k = 0; k < CHANNELS; k++) begin
      if (bus.cfg_load) begin
        sum_nxt[k*SW +: SW] = bus.in_valid ? sext(bus.sample_in[k*WIDTH +: WIDTH]) : '0;
      end else if (bus.in_valid) begin
        sum_nxt[k*SW +: SW] = sum_q[k*SW +: SW]
                            + sext(bus.sample_in[k*WIDTH +: WIDTH])
                            - ((state == RUN) ? sext(oldest[k*WIDTH +: WIDTH]) : '0);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath and control registers; reset leaves the window at MAX_DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      depth_q     <= DW'(MAX_DEPTH);
      fill_q      <= '0;
      wr_ptr      <= '0;
      sum_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      depth_q     <= depth_nxt;
      fill_q      <= fill_nxt;
      wr_ptr      <= wr_ptr_nxt;
      sum_q       <= sum_nxt;
      out_valid_q <= bus.in_valid;
    end
  end

  // Sample storage write, shared address across lanes.
  always_ff @(posedge clk) begin
    if (!rst && bus.in_valid) begin
      for (int k = 0; k < CHANNELS; k++) begin
        mem[k][wr_addr] <= bus.sample_in[k*WIDTH +: WIDTH];
      end
    end
  end

  assign bus.sum_out      = sum_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.sum_valid    = (state == RUN);
  assign bus.fill_level   = fill_q;
  assign bus.depth_active = depth_q;
endmodule

// File: tb/tb_minn_window_sum_mc.sv
// Purpose: directed self-checking bench for minn_window_sum_mc.
// Latency: results checked on the falling edge after the capturing rising edge.
// Backpressure: n/a; stimulus drives one sample per cycle or idles.
module tb_minn_window_sum_mc;
  localparam int WIDTH     = 16;
  localparam int MAX_DEPTH = 64;
  localparam int CHANNELS  = 2;
  localparam int DW        = $clog2(MAX_DEPTH + 1);
  localparam int SW        = WIDTH + DW;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  minn_window_sum_mc_if #(.WIDTH(WIDTH), .MAX_DEPTH(MAX_DEPTH), .CHANNELS(CHANNELS)) bus ();

  minn_window_sum_mc #(.WIDTH(WIDTH), .MAX_DEPTH(MAX_DEPTH), .CHANNELS(CHANNELS)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic signed [SW-1:0] sum0;
  logic signed [SW-1:0] sum1;
  assign sum0 = bus.sum_out[0 +: SW];
  assign sum1 = bus.sum_out[SW +: SW];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of inputs at a falling edge, return at the next falling edge.
  task automatic cycle(input logic cl, input int depth, input logic iv, input int s0, input int s1);
    bus.cfg_load  = cl;
    bus.cfg_depth = DW'(depth);
    bus.in_valid  = iv;
    bus.sample_in = {WIDTH'(s1), WIDTH'(s0)};
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle(1'b0, 0, 1'b0, 0, 0);
    cycle(1'b0, 0, 1'b0, 0, 0);
    n_cmp++; if (int'(sum0) !== 0) begin n_bad++; $display("FAIL reset_sum0: got %0d want 0", sum0); end
    n_cmp++; if (int'(sum1) !== 0) begin n_bad++; $display("FAIL reset_sum1: got %0d want 0", sum1); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.sum_valid !== 1'b0) begin n_bad++; $display("FAIL reset_sum_valid: got %b want 0", bus.sum_valid); end
    n_cmp++; if (int'(bus.fill_level) !== 0) begin n_bad++; $display("FAIL reset_fill: got %0d want 0", bus.fill_level); end
    n_cmp++; if (int'(bus.depth_active) !== 64) begin n_bad++; $display("FAIL reset_depth: got %0d want 64", bus.depth_active); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int exp_sum[6]  = '{1, 3, 6, 10, 14, 18};
    int exp_fill[6] = '{1, 2, 3, 4, 4, 4};
    cycle(1'b1, 4, 1'b0, 0, 0);
    n_cmp++; if (int'(bus.depth_active) !== 4) begin n_bad++; $display("FAIL basic_depth: got %0d want 4", bus.depth_active); end
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 0, 1'b1, i + 1, 0);
      n_cmp++; if (int'(sum0) !== exp_sum[i]) begin n_bad++; $display("FAIL basic_sum[%0d]: got %0d want %0d", i, sum0, exp_sum[i]); end
      n_cmp++; if (int'(bus.fill_level) !== exp_fill[i]) begin n_bad++; $display("FAIL basic_fill[%0d]: got %0d want %0d", i, bus.fill_level, exp_fill[i]); end
      n_cmp++; if (bus.sum_valid !== (i >= 3)) begin n_bad++; $display("FAIL basic_sum_valid[%0d]: got %b want %b", i, bus.sum_valid, (i >= 3)); end
      n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL basic_out_valid[%0d]: got %b want 1", i, bus.out_valid); end
    end
    cycle(1'b0, 0, 1'b0, 0, 0);
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_idle_ov: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_lanes();
    int pulses = 0;
    int exp_sum[5] = '{100, 200, 300, 300, 300};
    cycle(1'b1, 3, 1'b0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 0, 1'b1, 100, -100);
      if (bus.out_valid === 1'b1) pulses++;
      n_cmp++; if (int'(sum0) !== exp_sum[i]) begin n_bad++; $display("FAIL lanes_sum0[%0d]: got %0d want %0d", i, sum0, exp_sum[i]); end
      n_cmp++; if (int'(sum1) !== -exp_sum[i]) begin n_bad++; $display("FAIL lanes_sum1[%0d]: got %0d want %0d", i, sum1, -exp_sum[i]); end
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 0, 1'b0, 0, 0);
      if (bus.out_valid === 1'b1) pulses++;
    end
    n_cmp++; if (pulses !== 5) begin n_bad++; $display("FAIL lanes_pulses: got %0d want 5", pulses); end
  endtask

  task automatic test_gapped();
    int vals[3] = '{7, 8, 9};
    int exps[3] = '{7, 15, 17};
    int gaps[3] = '{3, 1, 0};
    cycle(1'b1, 2, 1'b0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 0, 1'b1, vals[i], 0);
      n_cmp++; if (int'(sum0) !== exps[i] || bus.out_valid !== 1'b1) begin
        n_bad++; $display("FAIL gap_sum[%0d]: got %0d/ov=%b want %0d/ov=1", i, sum0, bus.out_valid, exps[i]);
      end
      for (int g = 0; g < gaps[i]; g++) begin
        cycle(1'b0, 0, 1'b0, 0, 0);
        n_cmp++; if (int'(sum0) !== exps[i] || bus.out_valid !== 1'b0) begin
          n_bad++; $display("FAIL gap_hold[%0d.%0d]: got %0d/ov=%b want %0d/ov=0", i, g, sum0, bus.out_valid, exps[i]);
        end
      end
    end
  endtask

  task automatic test_clamp();
    int vals[3] = '{5, -3, 12};
    // Depth 0 with a coincident sample: N=1, window full at once.
    cycle(1'b1, 0, 1'b1, vals[0], 7);
    n_cmp++; if (int'(bus.depth_active) !== 1) begin n_bad++; $display("FAIL clamp_zero_depth: got %0d want 1", bus.depth_active); end
    n_cmp++; if (bus.sum_valid !== 1'b1) begin n_bad++; $display("FAIL clamp_n1_valid: got %b want 1", bus.sum_valid); end
    n_cmp++; if (int'(sum1) !== 7) begin n_bad++; $display("FAIL clamp_n1_sum1: got %0d want 7", sum1); end
    n_cmp++; if (int'(sum0) !== vals[0]) begin n_bad++; $display("FAIL clamp_n1_sum[0]: got %0d want %0d", sum0, vals[0]); end
    for (int i = 1; i < 3; i++) begin
      cycle(1'b0, 0, 1'b1, vals[i], 0);
      n_cmp++; if (int'(sum0) !== vals[i]) begin n_bad++; $display("FAIL clamp_n1_sum[%0d]: got %0d want %0d", i, sum0, vals[i]); end
    end
    // 200 truncates to 72 on the 7-bit port, still above MAX_DEPTH.
    cycle(1'b1, 200, 1'b0, 0, 0);
    n_cmp++; if (int'(bus.depth_active) !== 64) begin n_bad++; $display("FAIL clamp_big_depth: got %0d want 64", bus.depth_active); end
  endtask

  task automatic test_extremes();
    for (int i = 0; i < 64; i++) begin
      cycle(1'b0, 0, 1'b1, -32768, 0);
      if (i == 62) begin
        n_cmp++; if (bus.sum_valid !== 1'b0) begin n_bad++; $display("FAIL ext_valid_63: got %b want 0", bus.sum_valid); end
      end
    end
    n_cmp++; if (int'(sum0) !== -2097152) begin n_bad++; $display("FAIL ext_min_sum: got %0d want -2097152", sum0); end
    n_cmp++; if (bus.sum_valid !== 1'b1 || int'(bus.fill_level) !== 64) begin
      n_bad++; $display("FAIL ext_full: got valid=%b fill=%0d want 1/64", bus.sum_valid, bus.fill_level);
    end
    cycle(1'b0, 0, 1'b1, 32767, 0);
    n_cmp++; if (int'(sum0) !== -2031617) begin n_bad++; $display("FAIL ext_65th: got %0d want -2031617", sum0); end
  endtask

  task automatic test_reload();
    cycle(1'b1, 4, 1'b0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 0, 1'b1, 5, 0);
    n_cmp++; if (int'(sum0) !== 20) begin n_bad++; $display("FAIL reload_full: got %0d want 20", sum0); end
    cycle(1'b1, 2, 1'b1, 9, 0);
    n_cmp++; if (int'(sum0) !== 9 || int'(bus.fill_level) !== 1 || bus.sum_valid !== 1'b0) begin
      n_bad++; $display("FAIL reload_first: got sum=%0d fill=%0d valid=%b want 9/1/0", sum0, bus.fill_level, bus.sum_valid);
    end
    cycle(1'b0, 0, 1'b1, 1, 0);
    n_cmp++; if (int'(sum0) !== 10 || bus.sum_valid !== 1'b1) begin
      n_bad++; $display("FAIL reload_second: got sum=%0d valid=%b want 10/1", sum0, bus.sum_valid);
    end
    cycle(1'b0, 0, 1'b1, 2, 0);
    n_cmp++; if (int'(sum0) !== 3) begin n_bad++; $display("FAIL reload_third: got %0d want 3", sum0); end
    // Same N again still restarts.
    cycle(1'b1, 2, 1'b0, 0, 0);
    n_cmp++; if (int'(sum0) !== 0 || int'(bus.fill_level) !== 0 || bus.sum_valid !== 1'b0) begin
      n_bad++; $display("FAIL reload_same_n: got sum=%0d fill=%0d valid=%b want 0/0/0", sum0, bus.fill_level, bus.sum_valid);
    end
  endtask

  task automatic test_rst_mid();
    int exps[3] = '{4, 9, 15};
    cycle(1'b1, 4, 1'b0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 0, 1'b1, i + 1, i + 1);
    rst = 1'b1;
    cycle(1'b1, 2, 1'b1, 50, 50);
    rst = 1'b0;
    n_cmp++; if (int'(sum0) !== 0 || int'(sum1) !== 0 || bus.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL rst_mid_sums: got %0d/%0d ov=%b want 0/0/0", sum0, sum1, bus.out_valid);
    end
    n_cmp++; if (bus.sum_valid !== 1'b0 || int'(bus.fill_level) !== 0 || int'(bus.depth_active) !== 64) begin
      n_bad++; $display("FAIL rst_mid_ctrl: got valid=%b fill=%0d depth=%0d want 0/0/64", bus.sum_valid, bus.fill_level, bus.depth_active);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 0, 1'b1, i + 4, 0);
      n_cmp++; if (int'(sum0) !== exps[i] || int'(bus.fill_level) !== i + 1 || bus.sum_valid !== 1'b0) begin
        n_bad++; $display("FAIL rst_mid_refill[%0d]: got sum=%0d fill=%0d valid=%b want %0d/%0d/0", i, sum0, bus.fill_level, bus.sum_valid, exps[i], i + 1);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.cfg_load  = 1'b0;
    bus.cfg_depth = '0;
    bus.in_valid  = 1'b0;
    bus.sample_in = '0;
    test_reset();
    test_basic();
    test_lanes();
    test_gapped();
    test_clamp();
    test_extremes();
    test_reload();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/minn_window_sum_mc.md
Name: minn_window_sum_mc

Overview:
- Multi-channel sliding-window sum with a runtime-programmable window length (1..MAX_DEPTH).
- Successor to the fixed-depth single-channel running sum in the Minn timing-metric path.
- Sums CHANNELS lanes (e.g. I/Q or several correlator lags) in lockstep over the last N accepted samples.
- N can be reprogrammed without reset. Fill count is exposed for downstream gating.

Parameters:
- WIDTH, 16: signed sample width per channel.
- MAX_DEPTH, 64: maximum window length and buffer size; must be >= 1.
- CHANNELS, 2: number of parallel lanes; must be >= 1.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- cfg_depth  input  $clog2(MAX_DEPTH+1)  requested window length N; sampled only when cfg_load=1.
- cfg_load  input  1  latch cfg_depth and restart window.
- in_valid  input  1  sample strobe, one sample per lane per strobe.
- sample_in  input  CHANNELS*WIDTH  packed signed samples; lane k occupies bits [k*WIDTH +: WIDTH].
- sum_out  output  CHANNELS*SW  packed signed sums, SW = WIDTH+$clog2(MAX_DEPTH+1); lane k occupies bits [k*SW +: SW].
- out_valid  output  1  one-cycle pulse; sum_out was updated by an accepted sample.
- sum_valid  output  1  window holds N samples since last restart.
- fill_level  output  $clog2(MAX_DEPTH+1)  number of samples currently in window (0..N).
- depth_active  output  $clog2(MAX_DEPTH+1)  N currently in effect.

Behaviour:
- Reset values:
  - sum_out=0, out_valid=0, sum_valid=0, fill_level=0.
  - depth_active=MAX_DEPTH, write pointer=0.
  - Buffer contents are not cleared; correctness relies on fill gating.
- Depth clamp on cfg_load: cfg_depth=0 gives N=1; cfg_depth>MAX_DEPTH gives N=MAX_DEPTH.
- Restart on cfg_load (same cycle):
  - depth_active←clamped N, write pointer←0, fill_level←0, running sums←0, sum_valid←0.
  - No RAM clear.
- Circular buffer:
  - Per-lane storage of MAX_DEPTH words. Write pointer wraps from N-1 to 0, not MAX_DEPTH-1.
  - Oldest sample is the word at the write pointer, read before the overwrite in the same cycle.
- Per accepted sample (in_valid=1), per lane k:
  - next = sum + sext(sample_k) − (fill_level==N ? sext(oldest_k) : 0).
  - Full-width arithmetic, no saturation. SW bits cannot overflow for any N≤MAX_DEPTH.
- Latency:
  - sum_out and out_valid are registered; they appear on the cycle after in_valid is sampled.
  - sum_out includes the sample accepted that cycle.
- Fill and valid flags:
  - fill_level increments per accepted sample until it equals N, then holds.
  - sum_valid goes 1 on the same edge that fill_level reaches N. It stays 1 until rst or cfg_load.
- State machine, two states:
  - FILL (fill_level<N) → RUN on the sample that makes fill_level==N.
  - RUN → FILL only on cfg_load or rst.
  - With N=1, the first accepted sample moves FILL→RUN.
- Idle (in_valid=0, no cfg_load): sum_out holds, out_valid=0, nothing changes.
- cfg_load and in_valid in the same cycle:
  - Restart occurs and the sample is accepted as the first sample of the new window.
  - sum_out←sext(sample), out_valid=1, fill_level=1, sum_valid=(N==1).
- cfg_load with the same N as current still restarts.
- rst has priority over cfg_load and in_valid.
- rst mid-window discards all state. The first post-reset window needs MAX_DEPTH samples.
- Lanes are fully independent in data and share all control.

Test Plan:
- Default params, rst then cfg_load with N=4, lane0 samples 1,2,3,4,5,6:
  - lane0 sum_out = 1,3,6,10,14,18, each one cycle after its strobe.
  - sum_valid first high with the 10.
  - fill_level = 1,2,3,4,4,4.
- Lanes independent: lane0=+100 and lane1=−100 constant, N=3, 5 samples:
  - Sums are 100,200,300,300,300 and −100,−200,−300,−300,−300.
  - out_valid pulses exactly 5 times.
- Gapped input: N=2, samples 7 (gap 3 cycles) 8 (gap) 9:
  - sum_out 7,15,17, held constant during gaps, out_valid low in gaps.
- Clamp and extremes:
  - cfg_depth=0 gives depth_active=1, and sum_out equals each sample.
  - cfg_depth=200 gives depth_active=64.
  - 64 samples of −32768 give sum −2097152 with no wrap; the 65th sample of +32767 gives −2031617.
- Reload mid-run: N=4 full window of 5s (sum 20), then cfg_load N=2 together with sample 9:
  - sum_out=9, fill_level=1, sum_valid=0.
  - Next sample 1 gives 10 with sum_valid=1; next sample 2 gives 3.
- rst mid-window after 3 of 4 samples:
  - All outputs 0 and depth_active=64.
  - New samples restart the sum from zero with no stale-data subtraction.
